serial_adder_sub: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/full_adder_bit.sv | 20 ++
 rtl/serial_adder_sub.sv | 111 +++++++++++
 tb/tb_serial_adder_sub.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Bit counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder built from two half adders and an OR for the carry.
module full_adder_bit (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic w_s1;
   logic w_c1;
   logic w_c2;

   assign w_s1 = x ^ y;
   assign w_c1 = x & y;
   assign s    = w_s1 ^ cin;
   assign w_c2 = w_s1 & cin;
   assign cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, start/busy/done handshake.
//  state | meaning
//  IDLE  | waiting for start; result registers hold the last result
//  RUN   | one operand bit pair processed per clock, sum shifts in at the MSB
//  DONE  | one-cycle done pulse; start here begins the next operation at once
module serial_adder_sub
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int             CW     = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST   = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  PENULT = CW'(WIDTH - 2);

   state_t           r_state;
   logic [WIDTH-1:0] r_ra;
   logic [WIDTH-1:0] r_rb;
   logic [WIDTH-1:0] r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_cmsb;
   logic             r_cout;
   logic             r_ovf;
   logic             r_busy;
   logic             r_done;

   logic             w_s;
   logic             w_c;

   full_adder_bit u_fa (
      .x    (r_ra[0]),
      .y    (r_rb[0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ra    <= '0;
         r_rb    <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cmsb  <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  // Subtract as A + ~B + 1: invert B and seed the carry with 1.
                  r_ra    <= a;
                  r_rb    <= sub ? ~b : b;
                  r_carry <= sub;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_ra    <= r_ra >> 1;
               r_rb    <= r_rb >> 1;
               r_sum   <= {w_s, r_sum[WIDTH-1:1]};
               r_carry <= w_c;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == PENULT) begin
                  r_cmsb <= w_c;
               end
               if (r_cnt == LAST) begin
                  r_cout  <= w_c;
                  r_ovf   <= w_c ^ r_cmsb;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Scoreboard bench for serial_adder_sub: driver pushes expected results, monitor checks on done.
module tb_serial_adder_sub;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         v;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;

   serial_adder_sub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .sub   (sub),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain modular arithmetic and the sign rule for overflow.
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                 output logic [W-1:0] r, output logic c, output logic v);
      longint t;
      if (s) t = longint'(x) + ((longint'(1) << W) - longint'(y));
      else   t = longint'(x) + longint'(y);
      r = t[W-1:0];
      c = t[W];
      if (!s) v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      else    v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
   endfunction

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0:       v = '0;
         1:       v = '1;
         2:       v = {1'b1, {(W-1){1'b0}}};
         3:       v = {1'b0, {(W-1){1'b1}}};
         4:       v = W'(1);
         default: v = W'($urandom);
      endcase
      return v;
   endfunction

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("ready_timeout", 1, 0);
   endtask

   // Drive start in the current negedge window and record the accept edge.
   task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input logic [W-1:0] es, input logic ec, input logic ev);
      exp_t e;
      a = x;
      b = y;
      sub = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e.s = es;
      e.c = ec;
      e.v = ev;
      e.acc = cyc;
      q.push_back(e);
      a = W'($urandom);
      b = W'($urandom);
      sub = 1'($urandom);
   endtask

   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input logic [W-1:0] es, input logic ec, input logic ev);
      wait_ready();
      drive(x, y, s, es, ec, ev);
   endtask

   task automatic issue_rand();
      logic [W-1:0] x, y, r;
      logic         s, c, v;
      x = pick();
      y = pick();
      s = 1'($urandom);
      model(x, y, s, r, c, v);
      issue(x, y, s, r, c, v);
   endtask

   task automatic wait_drain();
      int n = 0;
      @(negedge clk);
      while ((q.size() != 0 || busy || done) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("drain_timeout", 1, 0);
   endtask

   task automatic wait_done();
      int n = 0;
      @(negedge clk);
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("done_timeout", 1, 0);
   endtask

   // Monitor: compares every done pulse with the oldest outstanding expectation.
   initial begin
      int   bcnt;
      exp_t e;
      bcnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bcnt = 0;
         end else begin
            if (busy) bcnt++;
            if (done) begin
               chk("busy_low_in_done", longint'(busy), 0);
               if (q.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  e = q.pop_front();
                  chk("sum", longint'(sum), longint'(e.s));
                  chk("cout", longint'(cout), longint'(e.c));
                  chk("ovf", longint'(ovf), longint'(e.v));
                  chk("latency", longint'(cyc - e.acc), W);
                  chk("busy_cycles", longint'(bcnt), W);
               end
               bcnt = 0;
            end
         end
      end
   end

   initial begin
      logic [W-1:0] held;
      bit           saw_done;

      #2;
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_sum", longint'(sum), 0);
      chk("rst_cout", longint'(cout), 0);
      chk("rst_ovf", longint'(ovf), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic add, then verify the result holds through IDLE.
      issue(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
      wait_drain();
      held = sum;
      repeat (3) @(negedge clk);
      chk("sum_held_idle", longint'(sum), 8'h10);
      chk("sum_held_stable", longint'(sum), longint'(held));

      issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      issue(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
      issue(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
      wait_drain();

      // Start during RUN is ignored; start during DONE is accepted immediately.
      issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      a = 8'hAA;
      b = 8'h55;
      sub = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done();
      drive(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
      wait_drain();

      // Asynchronous reset in the middle of RUN aborts with no done.
      issue(8'h33, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", longint'(busy), 0);
      chk("abort_done", longint'(done), 0);
      chk("abort_sum", longint'(sum), 0);
      chk("abort_cout", longint'(cout), 0);
      chk("abort_ovf", longint'(ovf), 0);
      void'(q.pop_back());
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      chk("no_done_after_abort", longint'(saw_done), 0);
      issue(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);
      wait_drain();

      // Randomised sweep, mixing back-to-back starts with idle gaps.
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         issue_rand();
      end
      wait_drain();
      chk("queue_empty", longint'(q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
